// File: rtl/reset_delay_pkg.sv
// Shared helpers for reset_delay_line: port/counter width math and the
// default stage reset value.
package reset_delay_pkg;

  // Widest WIDTH for which the default reset value is derived automatically.
  localparam int RV_MAX_WIDTH = 1024;

  // tap_sel width: at least one bit, even when DEPTH is 1.
  function automatic int tap_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Fill counter has to hold the value DEPTH itself.
  function automatic int fill_width(input int depth);
    return (depth > 0) ? $clog2(depth + 1) : 1;
  endfunction

  function automatic logic [RV_MAX_WIDTH-1:0] default_reset_value(input int width);
    logic [RV_MAX_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < RV_MAX_WIDTH; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/reset_delay_stage.sv
// One WIDTH-bit stage of the delay line: synchronous reset to RESET_VALUE,
// otherwise loads load_value on enabled edges.
module reset_delay_stage #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else if (enable) begin
      q <= load_value;
    end
  end

endmodule

// File: rtl/reset_delay_line.sv
// DEPTH-stage shift register with runtime tap, fill tracking and flush.
// Define RESET_DELAY_LINE_TAPS_EN to drive the flattened taps port; otherwise it reads zero.
module reset_delay_line
  import reset_delay_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(default_reset_value(WIDTH)),
  localparam int TAPW = tap_width(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       data_in,
  input  logic [TAPW-1:0]        tap_sel,
  output logic [WIDTH-1:0]       data_out,
  output logic [WIDTH-1:0]       data_tap,
  output logic                   primed,
  output logic [DEPTH*WIDTH-1:0] taps
);

  localparam int CW = fill_width(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] stage [DEPTH];
  logic [CW-1:0]    fill;
  logic             clear;

  // Reset and flush have the same effect on every stage, so one clear line
  // serves both; reset therefore trivially wins over flush and enable.
  assign clear = reset | flush;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] load_value;
    if (k == 0) begin : g_head
      assign load_value = data_in;
    end else begin : g_body
      assign load_value = stage[k-1];
    end

    reset_delay_stage #(
      .WIDTH      (WIDTH),
      .RESET_VALUE(RESET_VALUE)
    ) u_stage (
      .clock     (clock),
      .reset     (clear),
      .enable    (enable),
      .load_value(load_value),
      .q         (stage[k])
    );
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      fill <= '0;
    end else if (enable && (fill != FULL)) begin
      fill <= fill + CW'(1);
    end
  end

  assign primed   = (fill == FULL);
  assign data_out = stage[DEPTH-1];

  // Out-of-range tap_sel matches no stage and falls through to the last one.
  always_comb begin
    data_tap = stage[DEPTH-1];
    for (int k = 0; k < DEPTH; k++) begin
      if (32'(tap_sel) == k) data_tap = stage[k];
    end
  end

`ifdef RESET_DELAY_LINE_TAPS_EN
  for (genvar k = 0; k < DEPTH; k++) begin : g_taps
    assign taps[k*WIDTH +: WIDTH] = stage[k];
  end
`else
  assign taps = '0;
`endif

endmodule

// File: tb/tb_reset_delay_line.sv
// Bench for reset_delay_line: three instances (1x4, 8x4, 8x5) sharing one
// stimulus stream; hand-computed expectations are queued and checked on negedge.
module tb_reset_delay_line;

  localparam int EW = 59;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       fl  = 1'b0;
  logic       en  = 1'b0;
  logic [7:0] din = 8'h00;
  logic [2:0] ts  = 3'd0;

  logic        out_w1, tap_w1, pr_w1;
  logic [3:0]  taps_w1;
  logic [7:0]  out_w8, tap_w8;
  logic        pr_w8;
  logic [31:0] taps_w8;
  logic [7:0]  out_d5, tap_d5;
  logic        pr_d5;
  logic [39:0] taps_d5;

  reset_delay_line #(.WIDTH(1), .DEPTH(4)) u_w1 (
    .clock(clk), .reset(rst), .enable(en), .flush(fl), .data_in(din[0]),
    .tap_sel(ts[1:0]), .data_out(out_w1), .data_tap(tap_w1), .primed(pr_w1), .taps(taps_w1)
  );

  reset_delay_line #(.WIDTH(8), .DEPTH(4)) u_w8 (
    .clock(clk), .reset(rst), .enable(en), .flush(fl), .data_in(din),
    .tap_sel(ts[1:0]), .data_out(out_w8), .data_tap(tap_w8), .primed(pr_w8), .taps(taps_w8)
  );

  reset_delay_line #(.WIDTH(8), .DEPTH(5)) u_d5 (
    .clock(clk), .reset(rst), .enable(en), .flush(fl), .data_in(din),
    .tap_sel(ts), .data_out(out_d5), .data_tap(tap_d5), .primed(pr_d5), .taps(taps_d5)
  );

  // Entry layout: {dut[1:0], data_out[7:0], data_tap[7:0], primed, taps[39:0]}
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check(input string nm, input string field,
                       input logic [39:0] act, input logic [39:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s: got %0h, required %0h", nm, field, act, req);
  endtask

  task automatic step(input logic r, input logic f, input logic e,
                      input logic [7:0] d, input logic [2:0] t);
    @(negedge clk);
    #1;
    rst = r; fl = f; en = e; din = d; ts = t;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int dut, input logic [7:0] o, input logic [7:0] t,
                            input logic p, input logic [39:0] tp, input string nm);
    logic [39:0] tv;
    tv = tp;
`ifndef RESET_DELAY_LINE_TAPS_EN
    tv = '0;
`endif
    exp_q.push_back({2'(dut), o, t, p, tv});
    name_q.push_back(nm);
  endtask

  // Monitor
  logic [EW-1:0] mon_e;
  string         mon_nm;
  logic [7:0]    act_out, act_tap;
  logic          act_pr;
  logic [39:0]   act_taps;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      case (mon_e[58:57])
        2'd0: begin
          act_out = {7'b0, out_w1}; act_tap = {7'b0, tap_w1};
          act_pr = pr_w1; act_taps = {36'b0, taps_w1};
        end
        2'd1: begin
          act_out = out_w8; act_tap = tap_w8;
          act_pr = pr_w8; act_taps = {8'b0, taps_w8};
        end
        default: begin
          act_out = out_d5; act_tap = tap_d5;
          act_pr = pr_d5; act_taps = taps_d5;
        end
      endcase
      check(mon_nm, "data_out", {32'b0, act_out}, {32'b0, mon_e[56:49]});
      check(mon_nm, "data_tap", {32'b0, act_tap}, {32'b0, mon_e[48:41]});
      check(mon_nm, "primed",   {39'b0, act_pr},  {39'b0, mon_e[40]});
      check(mon_nm, "taps",     act_taps,         mon_e[39:0]);
    end
  end

  logic [7:0] sweep_exp [8];

  initial begin
    sweep_exp = '{8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA1, 8'hA1, 8'hA1};

    // Reset state of all three instances
    step(1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
    expect_out(0, 8'h01, 8'h01, 1'b0, 40'hF, "w1_reset");
    expect_out(1, 8'hFF, 8'hFF, 1'b0, 40'hFFFF_FFFF, "w8_reset");
    expect_out(2, 8'hFF, 8'hFF, 1'b0, 40'hFF_FFFF_FFFF, "d5_reset");

    // 1-bit line: zeros take four enabled edges to reach data_out
    step(1'b0, 1'b0, 1'b1, 8'h00, 3'd0); expect_out(0, 8'h01, 8'h00, 1'b0, 40'hE, "w1_e1");
    step(1'b0, 1'b0, 1'b1, 8'h00, 3'd0); expect_out(0, 8'h01, 8'h00, 1'b0, 40'hC, "w1_e2");
    step(1'b0, 1'b0, 1'b1, 8'h00, 3'd0); expect_out(0, 8'h01, 8'h00, 1'b0, 40'h8, "w1_e3");
    step(1'b0, 1'b0, 1'b1, 8'h00, 3'd3); expect_out(0, 8'h00, 8'h00, 1'b1, 40'h0, "w1_e4");
    step(1'b0, 1'b0, 1'b1, 8'h01, 3'd0); expect_out(0, 8'h00, 8'h01, 1'b1, 40'h1, "w1_sat");

    // 8-bit stream with enable gaps
    step(1'b1, 1'b0, 1'b0, 8'h00, 3'd0); expect_out(1, 8'hFF, 8'hFF, 1'b0, 40'hFFFF_FFFF, "w8_reset2");
    step(1'b0, 1'b0, 1'b1, 8'h11, 3'd0); expect_out(1, 8'hFF, 8'h11, 1'b0, 40'hFFFF_FF11, "w8_s1");
    step(1'b0, 1'b0, 1'b0, 8'hEE, 3'd0); expect_out(1, 8'hFF, 8'h11, 1'b0, 40'hFFFF_FF11, "w8_hold1");
    step(1'b0, 1'b0, 1'b1, 8'h22, 3'd0); expect_out(1, 8'hFF, 8'h22, 1'b0, 40'hFFFF_1122, "w8_s2");
    step(1'b0, 1'b0, 1'b1, 8'h33, 3'd0); expect_out(1, 8'hFF, 8'h33, 1'b0, 40'hFF11_2233, "w8_s3");
    step(1'b0, 1'b0, 1'b0, 8'hEE, 3'd0); expect_out(1, 8'hFF, 8'h33, 1'b0, 40'hFF11_2233, "w8_hold2");
    step(1'b0, 1'b0, 1'b1, 8'h44, 3'd1); expect_out(1, 8'h11, 8'h33, 1'b1, 40'h1122_3344, "w8_s4");

    // Flush after primed: 0x55 must never enter
    step(1'b0, 1'b1, 1'b1, 8'h55, 3'd0); expect_out(1, 8'hFF, 8'hFF, 1'b0, 40'hFFFF_FFFF, "w8_flush");
    step(1'b0, 1'b0, 1'b0, 8'h55, 3'd0); expect_out(1, 8'hFF, 8'hFF, 1'b0, 40'hFFFF_FFFF, "w8_flush_hold");
    step(1'b0, 1'b0, 1'b1, 8'h66, 3'd0); expect_out(1, 8'hFF, 8'h66, 1'b0, 40'hFFFF_FF66, "w8_after_flush");
    step(1'b0, 1'b0, 1'b1, 8'h77, 3'd1); expect_out(1, 8'hFF, 8'h66, 1'b0, 40'hFFFF_6677, "w8_mid");

    // Reset with flush and enable mid-stream, then a full refill
    step(1'b1, 1'b1, 1'b1, 8'h99, 3'd0); expect_out(1, 8'hFF, 8'hFF, 1'b0, 40'hFFFF_FFFF, "w8_rst_flush");
    step(1'b0, 1'b0, 1'b1, 8'h01, 3'd0);
    step(1'b0, 1'b0, 1'b1, 8'h02, 3'd0);
    step(1'b0, 1'b0, 1'b1, 8'h03, 3'd0); expect_out(1, 8'hFF, 8'h03, 1'b0, 40'hFF01_0203, "w8_refill3");
    step(1'b0, 1'b0, 1'b1, 8'h04, 3'd2); expect_out(1, 8'h01, 8'h02, 1'b1, 40'h0102_0304, "w8_refill4");

    // Depth-5 fill and tap sweep including out-of-range selects
    step(1'b1, 1'b0, 1'b0, 8'h00, 3'd0); expect_out(2, 8'hFF, 8'hFF, 1'b0, 40'hFF_FFFF_FFFF, "d5_reset2");
    step(1'b0, 1'b0, 1'b1, 8'hA1, 3'd0);
    step(1'b0, 1'b0, 1'b1, 8'hA2, 3'd0);
    step(1'b0, 1'b0, 1'b1, 8'hA3, 3'd0);
    step(1'b0, 1'b0, 1'b1, 8'hA4, 3'd0); expect_out(2, 8'hFF, 8'hA4, 1'b0, 40'hFF_A1A2_A3A4, "d5_fill4");
    step(1'b0, 1'b0, 1'b1, 8'hA5, 3'd0); expect_out(2, 8'hA1, 8'hA5, 1'b1, 40'hA1_A2A3_A4A5, "d5_fill5");
    for (int t = 0; t < 8; t++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00, 3'(t));
      expect_out(2, 8'hA1, sweep_exp[t], 1'b1, 40'hA1_A2A3_A4A5, $sformatf("d5_sweep%0d", t));
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
